// File: rtl/dif_uart_pkg.sv
// Shared types for the UART command path: FSM state encoding, frame header default,
// register-bus widths and the frame checksum helper.
package dif_uart_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam logic [7:0]  HEADER_DEFAULT = 8'hAA;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DHI   = 3'd2,
      ST_DLO   = 3'd3,
      ST_CSUM  = 3'd4,
      ST_WRITE = 3'd5,
      ST_ERROR = 3'd6
   } state_e;

   // Modulo-256 sum of the three payload bytes.
   function automatic logic [7:0] frame_csum(input logic [ADDR_W-1:0] addr,
                                             input logic [DATA_W-1:0] data);
      return addr + data[15:8] + data[7:0];
   endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear; expired is combinational,
// high once TIMEOUT_CYCLES-1 cycles have elapsed so the consumer reacts on the TIMEOUT_CYCLES-th edge.
module uart_byte_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 40000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART frame decoder (HEADER ADDR DHI DLO CSUM) issuing one held register write per good frame.
// Optional inter-byte timeout under UART_CMD_TIMEOUT_EN; all outputs are registered.
module uart_cmd_ctrl
   import dif_uart_pkg::*;
#(
   parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 40000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              rx_err,
   output logic              reg_wr_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic              reg_wr_ack,
   output logic              frame_err,
   output logic [15:0]       frame_cnt,
   output logic              busy
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              reg_wr_en_q, reg_wr_en_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;
   logic              byte_vld;
   logic              timer_expired;

   // A byte flagged with rx_err is never treated as data.
   assign byte_vld = rx_valid & ~rx_err;

`ifdef UART_CMD_TIMEOUT_EN
   logic timer_en;
   logic timer_clr;

   assign timer_en  = state_q inside {ST_ADDR, ST_DHI, ST_DLO, ST_CSUM};
   assign timer_clr = byte_vld | ~timer_en;

   uart_byte_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_byte_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (timer_expired)
   );
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timer_expired      = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      frame_cnt_d = frame_cnt_q;
      frame_err_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (byte_vld && rx_data == HEADER) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (rx_err) begin
               state_d = ST_ERROR;
            end else if (byte_vld) begin
               reg_addr_d = rx_data;
               state_d    = ST_DHI;
            end else if (timer_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_DHI: begin
            if (rx_err) begin
               state_d = ST_ERROR;
            end else if (byte_vld) begin
               reg_wdata_d[15:8] = rx_data;
               state_d           = ST_DLO;
            end else if (timer_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_DLO: begin
            if (rx_err) begin
               state_d = ST_ERROR;
            end else if (byte_vld) begin
               reg_wdata_d[7:0] = rx_data;
               state_d          = ST_CSUM;
            end else if (timer_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_CSUM: begin
            if (rx_err) begin
               state_d = ST_ERROR;
            end else if (byte_vld) begin
               state_d = (rx_data == frame_csum(reg_addr_q, reg_wdata_q)) ? ST_WRITE : ST_ERROR;
            end else if (timer_expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_WRITE: begin
            // Bytes arriving while the write is pending are dropped, but reported.
            if (byte_vld) begin
               frame_err_d = 1'b1;
            end
            if (reg_wr_ack) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end
         ST_ERROR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d == ST_ERROR) begin
         frame_err_d = 1'b1;
      end
      reg_wr_en_d = (state_d == ST_WRITE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         frame_cnt_q <= '0;
         reg_wr_en_q <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         frame_cnt_q <= frame_cnt_d;
         reg_wr_en_q <= reg_wr_en_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign reg_wr_en = reg_wr_en_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign frame_cnt = frame_cnt_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed and randomized frame stimulus against a frame-level outcome model.
module tb_uart_cmd_ctrl;

   localparam logic [7:0] HDR = 8'hAA;
   localparam int         TMO = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_err = 1'b0;
   logic        reg_wr_en;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_wr_ack = 1'b0;
   logic        frame_err;
   logic [15:0] frame_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int wr_done = 0;
   int last_len = 0;
   int hi_len = 0;
   int ack_delay = 0;
   bit prev_en = 0;
   bit stray_ack = 0;
   logic [7:0]  exp_addr = 8'h00;
   logic [15:0] exp_data = 16'h0000;
   int exp_cnt = 0;

   typedef struct {
      bit          write;
      bit          err;
      logic [7:0]  addr;
      logic [15:0] data;
   } outcome_t;

   uart_cmd_ctrl #(.HEADER(HDR), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_err     (rx_err),
      .reg_wr_en  (reg_wr_en),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wr_ack (reg_wr_ack),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outcome of one header-led frame: an rx_err on any payload byte aborts it,
   // otherwise the byte-sum rule decides between write and reject.
   function automatic outcome_t model_frame(input logic [7:0] a, dh, dl, cs, input int err_pos);
      outcome_t o;
      o.write = 0; o.err = 0; o.addr = a; o.data = {dh, dl};
      if (err_pos > 0)
         o.err = 1;
      else if (((int'(a) + int'(dh) + int'(dl)) % 256) == int'(cs))
         o.write = 1;
      else
         o.err = 1;
      return o;
   endfunction

   // Observer and acknowledger, evaluated away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         hi_len = 0;
         prev_en = 0;
         reg_wr_ack = 1'b0;
      end else begin
         if (frame_err) err_seen++;
         if (reg_wr_en) begin
            hi_len++;
            chk("wr_addr", 32'(reg_addr), 32'(exp_addr));
            chk("wr_data", 32'(reg_wdata), 32'(exp_data));
         end else if (prev_en) begin
            wr_done++;
            last_len = hi_len;
            hi_len = 0;
         end
         prev_en = reg_wr_en;
         reg_wr_ack = reg_wr_en ? (hi_len == ack_delay + 1) : stray_ack;
      end
   end

   // Called at (or just after) a falling edge; returns on the falling edge after sampling.
   task automatic send_byte(input logic [7:0] b, input logic e);
      rx_data = b;
      rx_valid = 1'b1;
      rx_err = e;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_err = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || reg_wr_en) && n < 300) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("idle_wait", 32'(busy), 32'd0);
   endtask

   initial begin
      int eb, wb, n;

      repeat (3) @(negedge clk);
      chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
      chk("rst_addr", 32'(reg_addr), 32'd0);
      chk("rst_wdata", 32'(reg_wdata), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Good frame, ack three cycles after the write request.
      eb = err_seen; wb = wr_done;
      exp_addr = 8'h12; exp_data = 16'h3456; ack_delay = 3;
      send_byte(HDR, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      send_byte(8'h9C, 0);
      chk("wr_rise", 32'(reg_wr_en), 32'd1);
      wait_idle();
      exp_cnt++;
      chk("good_writes", 32'(wr_done - wb), 32'd1);
      chk("good_len", 32'(last_len), 32'd4);
      chk("good_cnt", 32'(frame_cnt), 32'(exp_cnt));
      chk("good_err", 32'(err_seen - eb), 32'd0);

      // Bad checksum.
      eb = err_seen; wb = wr_done;
      send_byte(HDR, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      send_byte(8'h9D, 0);
      chk("bad_err_pulse", 32'(frame_err), 32'd1);
      wait_idle();
      chk("bad_busy_after", 32'(busy), 32'd0);
      chk("bad_writes", 32'(wr_done - wb), 32'd0);
      chk("bad_err", 32'(err_seen - eb), 32'd1);
      chk("bad_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // Leading junk ignored.
      eb = err_seen; wb = wr_done;
      exp_addr = 8'h01; exp_data = 16'h0002; ack_delay = 1;
      send_byte(8'h55, 0); send_byte(8'h00, 0); send_byte(HDR, 0); send_byte(8'h01, 0);
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
      wait_idle();
      exp_cnt++;
      chk("junk_writes", 32'(wr_done - wb), 32'd1);
      chk("junk_err", 32'(err_seen - eb), 32'd0);
      chk("junk_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // Silence after the address byte.
      eb = err_seen; wb = wr_done;
      exp_addr = 8'h12; exp_data = 16'h3456; ack_delay = 0;
`ifdef UART_CMD_TIMEOUT_EN
      send_byte(HDR, 0); send_byte(8'h12, 0);
      n = 0;
      while (n < 4 * TMO) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (frame_err) break;
      end
      chk("tmo_latency", 32'(n), 32'(TMO));
      wait_idle();
      chk("tmo_err", 32'(err_seen - eb), 32'd1);
      send_byte(HDR, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
      send_byte(8'h9C, 0);
      wait_idle();
      exp_cnt++;
      chk("tmo_next_writes", 32'(wr_done - wb), 32'd1);
`else
      send_byte(HDR, 0); send_byte(8'h12, 0);
      repeat (3 * TMO) @(negedge clk);
      chk("notmo_busy", 32'(busy), 32'd1);
      chk("notmo_err", 32'(err_seen - eb), 32'd0);
      send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h9C, 0);
      wait_idle();
      exp_cnt++;
      chk("notmo_writes", 32'(wr_done - wb), 32'd1);
`endif
      chk("silence_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // rx_err together with the DATA_LO byte.
      eb = err_seen; wb = wr_done;
      send_byte(HDR, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 1);
      wait_idle();
      chk("rxerr_err", 32'(err_seen - eb), 32'd1);
      chk("rxerr_writes", 32'(wr_done - wb), 32'd0);
      chk("rxerr_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         logic [7:0] fb [5];
         logic [7:0] jb;
         outcome_t   o;
         int         ep;
         bit         stray;
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            jb = 8'($urandom_range(0, 255));
            send_byte(jb, (jb == HDR) || ($urandom_range(0, 3) == 0));
         end
         fb[0] = HDR;
         fb[1] = 8'($urandom_range(0, 255));
         fb[2] = 8'($urandom_range(0, 255));
         fb[3] = 8'($urandom_range(0, 255));
         fb[4] = 8'((int'(fb[1]) + int'(fb[2]) + int'(fb[3])) % 256);
         if ($urandom_range(0, 3) == 0) fb[4] = fb[4] + 8'($urandom_range(1, 255));
         ep = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : -1;
         o = model_frame(fb[1], fb[2], fb[3], fb[4], ep);
         ack_delay = int'($urandom_range(0, 5));
         stray = o.write && ack_delay >= 3 && ($urandom_range(0, 3) == 0);
         stray_ack = ($urandom_range(0, 2) == 0);
         exp_addr = o.addr; exp_data = o.data;
         eb = err_seen; wb = wr_done;
         for (int k = 0; k < 5; k++) begin
            if (k > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (k == ep) begin
               send_byte(fb[k], 1);
               break;
            end
            send_byte(fb[k], 0);
         end
         if (stray) send_byte(8'($urandom_range(0, 255)), 0);
         wait_idle();
         stray_ack = 0;
         if (o.write) exp_cnt++;
         chk("rnd_writes", 32'(wr_done - wb), 32'(o.write));
         chk("rnd_err", 32'(err_seen - eb), 32'(int'(o.err) + int'(stray)));
         chk("rnd_cnt", 32'(frame_cnt), 32'(exp_cnt % 65536));
         if (o.write) chk("rnd_len", 32'(last_len), 32'(ack_delay + 1));
      end

      // Reset while a write is pending.
      wb = wr_done;
      exp_addr = 8'h21; exp_data = 16'h4365; ack_delay = 1000;
      send_byte(HDR, 0); send_byte(8'h21, 0); send_byte(8'h43, 0); send_byte(8'h65, 0);
      send_byte(8'hC9, 0);
      repeat (2) @(negedge clk);
      chk("prerst_wr_en", 32'(reg_wr_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstw_wr_en", 32'(reg_wr_en), 32'd0);
      chk("rstw_cnt", 32'(frame_cnt), 32'd0);
      chk("rstw_busy", 32'(busy), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      exp_cnt = 0; ack_delay = 0;
      chk("rstw_writes", 32'(wr_done - wb), 32'd0);
      @(negedge clk);

      // Counter wrap: the preload stands in for 65535 earlier good frames.
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      wb = wr_done;
      exp_addr = 8'h01; exp_data = 16'h0203;
      send_byte(HDR, 0); send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
      send_byte(8'h06, 0);
      wait_idle();
      chk("wrap_writes", 32'(wr_done - wb), 32'd1);
      chk("wrap_cnt", 32'(frame_cnt), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
